// File: rtl/flow_ctrl_fsm.sv
// Link controller for the 4-lane PHY datapath: sequences RESET/INIT/IDLE/ACTIVE/ERROR,
// latches pause thresholds during INIT and drives per-lane hysteretic back-pressure.
module flow_ctrl_fsm #(
    parameter int LANES = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clk4f,
    input  logic                   reset,
    input  logic                   init,
    input  logic [CNT_W-1:0]       th_hi_in,
    input  logic [CNT_W-1:0]       th_lo_in,
    input  logic [LANES*CNT_W-1:0] fifo_cnt,
    input  logic [LANES-1:0]       fifo_ovf,
    output logic [2:0]             state_out,
    output logic                   active_out,
    output logic                   idle_out,
    output logic                   error_out,
    output logic [CNT_W-1:0]       th_hi_out,
    output logic [CNT_W-1:0]       th_lo_out,
    output logic [LANES-1:0]       pause_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEF_HI_C = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] DEF_LO_C = CNT_W'(2);

    state_t           state, state_nx;
    logic             any_bad, any_busy;
    logic [CNT_W-1:0] th_hi_nx, th_lo_nx;
    logic [LANES-1:0] pause_nx;
    logic             active_nx, idle_nx, error_nx;

    function automatic logic thresholds_ok(input logic [CNT_W-1:0] hi,
                                           input logic [CNT_W-1:0] lo);
        return (lo < hi) && (hi <= DEPTH_C);
    endfunction

    function automatic logic lane_bad(input logic [CNT_W-1:0] cnt, input logic ovf);
        return ovf || (cnt > DEPTH_C);
    endfunction

    always_comb begin
        any_bad  = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_bad(fifo_cnt[i*CNT_W +: CNT_W], fifo_ovf[i]))
                any_bad = 1'b1;
            if (fifo_cnt[i*CNT_W +: CNT_W] != '0)
                any_busy = 1'b1;
        end
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset)
            state <= ST_RESET;
        else
            state <= state_nx;
    end

    // Bad lanes outrank init, which outranks occupancy.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET:  state_nx = ST_INIT;
            ST_INIT:   state_nx = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (any_bad)       state_nx = ST_ERROR;
                else if (init)     state_nx = ST_INIT;
                else if (any_busy) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_bad)        state_nx = ST_ERROR;
                else if (init)      state_nx = ST_INIT;
                else if (!any_busy) state_nx = ST_IDLE;
            end
            ST_ERROR:  state_nx = ST_ERROR;
            default:   state_nx = ST_ERROR;
        endcase
    end

    always_comb begin
        th_hi_nx  = th_hi_out;
        th_lo_nx  = th_lo_out;
        pause_nx  = pause_out;
        active_nx = (state_nx == ST_ACTIVE);
        idle_nx   = (state_nx == ST_IDLE);
        error_nx  = (state_nx == ST_ERROR);

        if (state == ST_INIT) begin
            if (init) begin
                th_hi_nx = th_hi_in;
                th_lo_nx = th_lo_in;
            end else if (!thresholds_ok(th_hi_out, th_lo_out)) begin
                th_hi_nx = DEF_HI_C;
                th_lo_nx = DEF_LO_C;
            end
        end

        // Hysteresis only runs once the FSM already sits in IDLE/ACTIVE.
        case (state_nx)
            ST_ERROR:          pause_nx = '1;
            ST_RESET, ST_INIT: pause_nx = '0;
            default: begin
                if (state == ST_IDLE || state == ST_ACTIVE) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (fifo_cnt[i*CNT_W +: CNT_W] >= th_hi_out)
                            pause_nx[i] = 1'b1;
                        else if (fifo_cnt[i*CNT_W +: CNT_W] <= th_lo_out)
                            pause_nx[i] = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
            th_hi_out  <= '0;
            th_lo_out  <= '0;
            pause_out  <= '0;
        end else begin
            active_out <= active_nx;
            idle_out   <= idle_nx;
            error_out  <= error_nx;
            th_hi_out  <= th_hi_nx;
            th_lo_out  <= th_lo_nx;
            pause_out  <= pause_nx;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed plus randomized bench for flow_ctrl_fsm against a cycle-level reference model.
module tb_flow_ctrl_fsm;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic                   clk4f = 1'b0;
    logic                   reset = 1'b1;
    logic                   init = 1'b0;
    logic [CNT_W-1:0]       th_hi_in = '0;
    logic [CNT_W-1:0]       th_lo_in = '0;
    logic [LANES*CNT_W-1:0] fifo_cnt = '0;
    logic [LANES-1:0]       fifo_ovf = '0;
    logic [2:0]             state_out;
    logic                   active_out, idle_out, error_out;
    logic [CNT_W-1:0]       th_hi_out, th_lo_out;
    logic [LANES-1:0]       pause_out;

    int total = 0;
    int bad = 0;

    // Reference model: link state number, thresholds, per-lane pause
    int m_state;
    int m_hi;
    int m_lo;
    bit m_pause [LANES];

    int ramp  [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int exp_p [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    flow_ctrl_fsm #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk4f     (clk4f),
        .reset     (reset),
        .init      (init),
        .th_hi_in  (th_hi_in),
        .th_lo_in  (th_lo_in),
        .fifo_cnt  (fifo_cnt),
        .fifo_ovf  (fifo_ovf),
        .state_out (state_out),
        .active_out(active_out),
        .idle_out  (idle_out),
        .error_out (error_out),
        .th_hi_out (th_hi_out),
        .th_lo_out (th_lo_out),
        .pause_out (pause_out)
    );

    always #5 clk4f = ~clk4f;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES-1:0] model_pause_vec();
        logic [LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i] = m_pause[i];
        return v;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_state"},  32'(state_out),  32'(m_state));
        chk({tag, "_active"}, 32'(active_out), 32'(m_state == 3));
        chk({tag, "_idle"},   32'(idle_out),   32'(m_state == 2));
        chk({tag, "_error"},  32'(error_out),  32'(m_state == 4));
        chk({tag, "_thhi"},   32'(th_hi_out),  32'(m_hi));
        chk({tag, "_thlo"},   32'(th_lo_out),  32'(m_lo));
        chk({tag, "_pause"},  32'(pause_out),  32'(model_pause_vec()));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_hi = 0;
        m_lo = 0;
        for (int i = 0; i < LANES; i++) m_pause[i] = 1'b0;
    endtask

    // Apply the link rules to the inputs present at the coming clock edge.
    task automatic model_step();
        int ns;
        int c;
        bit anybad = 1'b0;
        bit anyne = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            c = int'(fifo_cnt[i*CNT_W +: CNT_W]);
            if (fifo_ovf[i] || c > DEPTH) anybad = 1'b1;
            if (c != 0) anyne = 1'b1;
        end
        if (m_state == 0) ns = 1;
        else if (m_state == 1) begin
            if (init) begin
                ns = 1;
                m_hi = int'(th_hi_in);
                m_lo = int'(th_lo_in);
            end else begin
                ns = 2;
                if (!(m_lo < m_hi && m_hi <= DEPTH)) begin
                    m_hi = DEPTH - 2;
                    m_lo = 2;
                end
            end
        end else if (m_state == 2 || m_state == 3) begin
            if (anybad) ns = 4;
            else if (init) ns = 1;
            else ns = anyne ? 3 : 2;
        end else ns = 4;

        for (int i = 0; i < LANES; i++) begin
            c = int'(fifo_cnt[i*CNT_W +: CNT_W]);
            if (ns == 4) m_pause[i] = 1'b1;
            else if (ns < 2) m_pause[i] = 1'b0;
            else if (m_state == 2 || m_state == 3) begin
                if (c >= m_hi) m_pause[i] = 1'b1;
                else if (c <= m_lo) m_pause[i] = 1'b0;
            end
        end
        m_state = ns;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk4f);
        #1;
        chk_model(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        chk({tag, "_state0"},  32'(state_out),  32'd0);
        chk({tag, "_active0"}, 32'(active_out), 32'd0);
        chk({tag, "_pause0"},  32'(pause_out),  32'd0);
        chk({tag, "_thhi0"},   32'(th_hi_out),  32'd0);
        chk({tag, "_error0"},  32'(error_out),  32'd0);
        model_reset();
        @(posedge clk4f);
        #1;
        chk_model({tag, "_held"});
        #3 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk4f);
        #1;
        chk_model("rst");
        chk("rst_idle", 32'(idle_out), 32'd0);
        #3 reset = 1'b0;

        // Configuration with legal thresholds
        init = 1'b1;
        th_hi_in = 4'd6;
        th_lo_in = 4'd2;
        step("t1_c1");
        chk("t1_s1", 32'(state_out), 32'd1);
        step("t1_c2");
        step("t1_c3");
        chk("t1_s3", 32'(state_out), 32'd1);
        init = 1'b0;
        step("t1_c4");
        chk("t1_s4", 32'(state_out), 32'd2);
        chk("t1_hi", 32'(th_hi_out), 32'd6);
        chk("t1_lo", 32'(th_lo_out), 32'd2);
        chk("t1_idle", 32'(idle_out), 32'd1);

        // Illegal thresholds fall back to defaults
        init = 1'b1;
        th_hi_in = 4'd3;
        th_lo_in = 4'd5;
        step("t2_c1");
        step("t2_c2");
        chk("t2_lat", 32'(th_hi_out), 32'd3);
        init = 1'b0;
        step("t2_c3");
        chk("t2_s", 32'(state_out), 32'd2);
        chk("t2_hi", 32'(th_hi_out), 32'd6);
        chk("t2_lo", 32'(th_lo_out), 32'd2);

        // Activity in and out
        fifo_cnt = 16'h0001;
        step("t3_act");
        chk("t3_active", 32'(active_out), 32'd1);
        fifo_cnt = '0;
        step("t3_idle");
        chk("t3_idle1", 32'(idle_out), 32'd1);

        // Hysteresis ramp on lane 2
        for (int k = 0; k < 15; k++) begin
            fifo_cnt = '0;
            fifo_cnt[11:8] = 4'(ramp[k]);
            step("t4_ramp");
            chk("t4_p2", 32'(pause_out[2]), 32'(exp_p[k]));
        end

        // Async reset mid-ACTIVE, then restart with default thresholds
        fifo_cnt = 16'h0001;
        step("t6_act");
        chk("t6_s3", 32'(state_out), 32'd3);
        async_reset("t6");
        fifo_cnt = '0;
        step("t6_r1");
        chk("t6_init", 32'(state_out), 32'd1);
        step("t6_r2");
        chk("t6_idle", 32'(state_out), 32'd2);
        chk("t6_hi", 32'(th_hi_out), 32'd6);

        // Randomized traffic and reconfiguration
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3, 0) == 0) fifo_cnt = '0;
            else for (int i = 0; i < LANES; i++) fifo_cnt[i*CNT_W +: CNT_W] = 4'($urandom_range(DEPTH, 0));
            init = ($urandom_range(15, 0) == 0);
            th_hi_in = 4'($urandom_range(15, 0));
            th_lo_in = 4'($urandom_range(15, 0));
            step("rand");
        end

        // Error beats init
        init = 1'b0;
        fifo_cnt = 16'h1111;
        step("t5_pre1");
        step("t5_pre2");
        chk("t5_s3", 32'(state_out), 32'd3);
        fifo_ovf = 4'b1000;
        init = 1'b1;
        step("t5_err");
        chk("t5_s4", 32'(state_out), 32'd4);
        chk("t5_eo", 32'(error_out), 32'd1);
        chk("t5_pause", 32'(pause_out), 32'hf);
        fifo_ovf = '0;
        for (int k = 0; k < 4; k++) begin
            init = ~init;
            step("t5_sticky");
            chk("t5_s4b", 32'(state_out), 32'd4);
        end

        // Occupancy boundary: DEPTH is legal, DEPTH+1 is bad
        async_reset("bd");
        init = 1'b0;
        fifo_cnt = '0;
        step("bd_r1");
        step("bd_r2");
        fifo_cnt[7:4] = 4'd8;
        step("bd_full");
        chk("bd_s3", 32'(state_out), 32'd3);
        chk("bd_p1", 32'(pause_out[1]), 32'd1);
        fifo_cnt[7:4] = 4'd9;
        step("bd_over");
        chk("bd_s4", 32'(state_out), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
